aes_ctr_scheduler: RTL

- Sequences the fully pipelined AES-128 encryptor (one block/cycle, fixed latency, no stall input) in counter mode to produce a stream of pseudorandom 128-bit blocks for the correlated-randomness generator.
- Loads key/seed/block count on a start command, issues counter blocks into the pipeline under credit control and buffers pipeline outputs in an internal FIFO.
- Presents the buffered blocks to a downstream consumer over a valid/ready interface.

---
 rtl/aes_ctr_scheduler.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/aes_ctr_scheduler.sv
// aes_ctr_scheduler
// Drives a fixed-latency, fully pipelined AES-128 encryptor in counter mode
// and buffers its ciphertext in a first-word-fall-through FIFO for a
// valid/ready consumer.
//
// State  | meaning
// IDLE   | waiting for cfg_start; captures key/seed/nblk
// RUN    | issuing counter blocks under credit control
// DRAIN  | all blocks issued; waiting for pipeline and FIFO to empty
// DONE   | one-cycle cfg_done pulse, then back to IDLE
//
// Ports
//   CLK, RST              clock, synchronous active-high reset
//   cfg_start/key/seed/nblk  job configuration, sampled in IDLE
//   cfg_busy, cfg_done    job status
//   err_ovf               sticky overflow flag (pipeline output into full FIFO)
//   aes_kin/din/drdy      pipeline issue side
//   aes_dout/dvld         pipeline result side
//   rnd_data/valid/ready  consumer stream
module aes_ctr_scheduler #(
  parameter int AES_LAT    = 11,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_start,
  input  logic [127:0]     cfg_key,
  input  logic [127:0]     cfg_seed,
  input  logic [CNT_W-1:0] cfg_nblk,
  output logic             cfg_busy,
  output logic             cfg_done,
  output logic             err_ovf,
  output logic [127:0]     aes_kin,
  output logic [127:0]     aes_din,
  output logic             aes_drdy,
  input  logic [127:0]     aes_dout,
  input  logic             aes_dvld,
  output logic [127:0]     rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) || (AES_LAT < 1)) begin : g_param_check
    $error("aes_ctr_scheduler: FIFO_DEPTH must be a power of two >= 2 and AES_LAT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [127:0]     key_q, seed_q;
  logic [CNT_W-1:0] nblk_q, issued_q;
  logic [CW-1:0]    inflight_q, count_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [127:0]     mem [FIFO_DEPTH];
  logic             err_q;

  logic active, issue, pop, push, full, dvld_ok, ovf;
  logic [CW:0] credit_used;

  // Credit counts blocks already in the pipeline plus blocks buffered, so the
  // FIFO can never be asked to take more than it holds.
  assign credit_used = {1'b0, inflight_q} + {1'b0, count_q};
  assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign issue       = (state_q == S_RUN) && (issued_q < nblk_q) &&
                       (credit_used < (CW+1)'(FIFO_DEPTH));
  assign rnd_valid   = (count_q != '0);
  assign pop         = rnd_valid && rnd_ready;
  assign full        = (count_q == CW'(FIFO_DEPTH));
  // Results arriving with nothing outstanding are stale (e.g. from an aborted job).
  assign dvld_ok     = aes_dvld && active && (inflight_q != '0);
  assign push        = dvld_ok && (!full || pop);
  assign ovf         = dvld_ok && full && !pop;

  assign aes_drdy = issue;
  assign aes_din  = issue ? {seed_q[127:CNT_W], seed_q[CNT_W-1:0] + issued_q} : '0;
  assign aes_kin  = key_q;
  assign rnd_data = rnd_valid ? mem[rd_ptr_q] : '0;
  assign cfg_busy = active;
  assign cfg_done = (state_q == S_DONE);
  assign err_ovf  = err_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_start) state_d = (cfg_nblk == '0) ? S_DONE : S_RUN;
      S_RUN:   if (issued_q == nblk_q) state_d = S_DRAIN;
      S_DRAIN: if ((inflight_q == '0) &&
                   ((count_q == '0) || ((count_q == CW'(1)) && pop)))
                 state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      key_q      <= '0;
      seed_q     <= '0;
      nblk_q     <= '0;
      issued_q   <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == S_IDLE) && cfg_start) begin
        key_q    <= cfg_key;
        seed_q   <= cfg_seed;
        nblk_q   <= cfg_nblk;
        issued_q <= '0;
      end else if (issue) begin
        issued_q <= issued_q + CNT_W'(1);
      end
      case ({issue, dvld_ok})
        2'b10:   inflight_q <= inflight_q + CW'(1);
        2'b01:   inflight_q <= inflight_q - CW'(1);
        default: inflight_q <= inflight_q;
      endcase
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (ovf)  err_q    <= 1'b1;
    end
  end

  // Storage needs no reset; rnd_data is masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr_q] <= aes_dout;
  end

endmodule
